// File: rtl/cfg_tile.sv
// Parametrised logic tile (CLB + BL/TR connection blocks + switch block) with a
// double-buffered word-serial configuration loader. Optional macro: CFG_READBACK_EN.
module cfg_tile #(
  parameter  int W         = 3,
  parameter  int CFG_DW    = 8,
  localparam int CFG_BITS  = 23 + 8 * W,
  localparam int CFG_WORDS = (CFG_BITS + CFG_DW - 1) / CFG_DW,
  localparam int RD_AW     = (CFG_WORDS > 1) ? $clog2(CFG_WORDS) : 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              cfg_valid,
  output logic              cfg_ready,
  input  logic [CFG_DW-1:0] cfg_data,
  input  logic              cfg_last,
  output logic              cfg_done,
  output logic              cfg_err,
`ifdef CFG_READBACK_EN
  input  logic [RD_AW-1:0]  cfg_rd_addr,
  output logic [CFG_DW-1:0] cfg_rd_data,
`endif
  input  logic              cl_V_i,
  input  logic              cl_H_i,
  input  logic              lc_V_i,
  input  logic              lc_H_i,
  input  logic [W-1:0]      sc_H_i,
  input  logic [W-1:0]      sc_V_i,
  output logic              lc_V_o,
  output logic              lc_H_o,
  output logic              cl_V_o,
  output logic              cl_H_o,
  output logic [W-1:0]      sc_H_o,
  output logic [W-1:0]      sc_V_o
);

  localparam int CNT_W  = $clog2(CFG_WORDS + 1);
  localparam int BL_LSB = 21;
  localparam int TR_LSB = 22 + 2 * W;
  localparam int SB_LSB = 23 + 4 * W;
  localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(CFG_WORDS - 1);

  typedef enum logic [1:0] {ST_IDLE, ST_LOAD, ST_COMMIT, ST_DRAIN} state_t;

  state_t               state_q, state_d;
  logic [CNT_W-1:0]     cnt_q, word_idx;
  logic [CFG_BITS-1:0]  shadow_q, shadow_d, active_q;
  logic                 in_frame, accept, load_word, is_final, frame_err;

  // ---------------------------------------------------------------- loader FSM
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end

  // NOTE: every signal written in always_comb gets a default first, so no path
  // leaves it unassigned and no latch is inferred.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE, ST_LOAD:
        if (accept) begin
          if (cfg_last)      state_d = is_final ? ST_COMMIT : ST_IDLE;
          else if (is_final) state_d = ST_DRAIN;
          else               state_d = ST_LOAD;
        end
      ST_COMMIT: state_d = ST_IDLE;
      ST_DRAIN:  if (accept && cfg_last) state_d = ST_IDLE;
      default:   state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    cfg_ready = (state_q != ST_COMMIT);
    cfg_done  = (state_q == ST_COMMIT);
    in_frame  = (state_q == ST_IDLE) || (state_q == ST_LOAD);
  end

  assign accept    = cfg_valid & cfg_ready;
  assign load_word = accept & in_frame;
  // The first word of a frame is taken in IDLE, so it is always word 0.
  assign word_idx  = (state_q == ST_IDLE) ? '0 : cnt_q;
  assign is_final  = (word_idx == LAST_IDX);
  assign frame_err = load_word & (cfg_last ? !is_final : is_final);

  // Each shadow bit belongs to a fixed word; padding bits of the last word are dropped.
  for (genvar j = 0; j < CFG_BITS; j++) begin : g_shadow
    localparam int WJ = j / CFG_DW;
    localparam int BJ = j % CFG_DW;
    assign shadow_d[j] = (load_word && word_idx == CNT_W'(WJ)) ? cfg_data[BJ] : shadow_q[j];
  end

  // NOTE: sequential state uses non-blocking assignments only, so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shadow_q <= '0;
      active_q <= '0;
      cnt_q    <= '0;
      cfg_err  <= 1'b0;
    end else begin
      shadow_q <= shadow_d;
      if (load_word) cnt_q <= word_idx + 1'b1;
      if (state_q == ST_COMMIT) active_q <= shadow_q;
      if (frame_err)                         cfg_err <= 1'b1;
      else if (accept && state_q == ST_IDLE) cfg_err <= 1'b0;
    end
  end

  // ---------------------------------------------------------------- fabric
  logic [15:0]    lut;
  logic           ff_sel, en_up, en_right, en_down, en_left;
  logic [W-1:0]   bl_sel_in, bl_sel_out, tr_sel_in, tr_sel_out;
  logic           bl_pass, tr_pass;
  logic [4*W-1:0] sb_cfg;

  assign lut    = active_q[15:0];
  assign ff_sel = active_q[16];
  assign {en_left, en_down, en_right, en_up}   = active_q[20:17];
  assign {bl_pass, bl_sel_out, bl_sel_in}      = active_q[BL_LSB +: 2*W+1];
  assign {tr_pass, tr_sel_out, tr_sel_in}      = active_q[TR_LSB +: 2*W+1];
  assign sb_cfg = active_q[SB_LSB +: 4*W];

  logic       bl_to_clb, tr_to_clb, lut_f, lut_q, clb_r;
  logic [3:0] lut_idx;
  logic [W-1:0] bl_trk, tr_trk;

  assign bl_to_clb = |(sc_H_i & bl_sel_in);
  assign tr_to_clb = |(sc_V_i & tr_sel_in);
  assign lut_idx   = {cl_V_i, tr_to_clb, bl_to_clb, cl_H_i};
  assign lut_f     = lut[lut_idx];

  // The DFF tracks the LUT every cycle and is deliberately left alone by a commit.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) lut_q <= 1'b0;
    else        lut_q <= lut_f;
  end

  assign clb_r  = ff_sel ? lut_q : lut_f;
  assign lc_V_o = clb_r & en_up;
  assign lc_H_o = clb_r & en_left;

  assign bl_trk = sc_H_i | ({W{clb_r & en_down}}  & bl_sel_out);
  assign tr_trk = sc_V_i | ({W{clb_r & en_right}} & tr_sel_out);
  assign cl_V_o = lc_V_i & bl_pass;
  assign cl_H_o = lc_H_i & tr_pass;

  for (genvar i = 0; i < W; i++) begin : g_sblock
    logic [3:0] s;
    assign s         = sb_cfg[4*i +: 4];
    assign sc_H_o[i] = (bl_trk[i] & s[0]) | (tr_trk[i] & s[1]);
    assign sc_V_o[i] = (bl_trk[i] & s[2]) | (tr_trk[i] & s[3]);
  end

  // ---------------------------------------------------------------- readback
`ifdef CFG_READBACK_EN
  logic [CFG_WORDS*CFG_DW-1:0] rd_padded;
  logic [CFG_DW-1:0]           rd_word;

  for (genvar j = 0; j < CFG_WORDS * CFG_DW; j++) begin : g_rd_pad
    if (j < CFG_BITS) begin : g_bit
      assign rd_padded[j] = active_q[j];
    end else begin : g_zero
      assign rd_padded[j] = 1'b0;
    end
  end

  // Unmatched (out-of-range) addresses fall through to zero.
  always_comb begin
    rd_word = '0;
    for (int k = 0; k < CFG_WORDS; k++)
      if (cfg_rd_addr == RD_AW'(k)) rd_word = rd_padded[k*CFG_DW +: CFG_DW];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) cfg_rd_data <= '0;
    else        cfg_rd_data <= rd_word;
  end
`else
  // Without readback the active register is observable only through the fabric.
`endif

endmodule

// File: tb/tb_cfg_tile.sv
// Directed, table-driven bench for cfg_tile (W=3, CFG_DW=8, 6 words per frame).
module tb_cfg_tile;

  localparam int W = 3;
  localparam int DW = 8;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          cfg_valid, cfg_ready, cfg_last, cfg_done, cfg_err;
  logic [DW-1:0] cfg_data;
  logic          cl_V_i, cl_H_i, lc_V_i, lc_H_i;
  logic [W-1:0]  sc_H_i, sc_V_i;
  logic          lc_V_o, lc_H_o, cl_V_o, cl_H_o;
  logic [W-1:0]  sc_H_o, sc_V_o;
  logic [9:0]    outs;

  int n_cmp = 0;
  int n_bad = 0;
  int done_cnt = 0;

  cfg_tile #(.W(W), .CFG_DW(DW)) dut (
    .clk(clk), .rst_n(rst_n),
    .cfg_valid(cfg_valid), .cfg_ready(cfg_ready), .cfg_data(cfg_data),
    .cfg_last(cfg_last), .cfg_done(cfg_done), .cfg_err(cfg_err),
    .cl_V_i(cl_V_i), .cl_H_i(cl_H_i), .lc_V_i(lc_V_i), .lc_H_i(lc_H_i),
    .sc_H_i(sc_H_i), .sc_V_i(sc_V_i),
    .lc_V_o(lc_V_o), .lc_H_o(lc_H_o), .cl_V_o(cl_V_o), .cl_H_o(cl_H_o),
    .sc_H_o(sc_H_o), .sc_V_o(sc_V_o)
  );

  always #5 clk = ~clk;

  assign outs = {lc_V_o, lc_H_o, cl_V_o, cl_H_o, sc_H_o, sc_V_o};

  always @(negedge clk) if (cfg_done === 1'b1) done_cnt++;

  // Inputs plus expected {lc_V_o, lc_H_o, cl_V_o, cl_H_o, sc_H_o, sc_V_o}.
  typedef struct {
    logic       cl_v, cl_h, lc_v, lc_h;
    logic [2:0] sc_h, sc_v;
    logic [9:0] exp;
  } vec_t;

  vec_t vecs[5];
  vec_t v_err, v_ones;

  // F1: LUT=8000, en up+down, BL sel_in0/sel_out2/pass, TR sel_in0,
  //     S-block trk0 s0, trk1 s3, trk2 s1+s2. F2 adds ff_sel.
  logic [47:0] f1 = 48'h34081C2A8000;
  logic [47:0] f2 = 48'h34081C2B8000;
  logic [47:0] fz = 48'h0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input vec_t v);
    cl_V_i = v.cl_v; cl_H_i = v.cl_h; lc_V_i = v.lc_v; lc_H_i = v.lc_h;
    sc_H_i = v.sc_h; sc_V_i = v.sc_v;
  endtask

  task automatic apply_vec(input vec_t v, input string name);
    drive(v);
    tick();
    check(name, 32'(outs), 32'(v.exp));
  endtask

  task automatic send_word(input logic [7:0] d, input logic last);
    int guard = 0;
    cfg_valid = 1'b1; cfg_data = d; cfg_last = last;
    while (cfg_ready !== 1'b1 && guard < 10) begin
      tick();
      guard++;
    end
    if (cfg_ready !== 1'b1) check("ready_timeout", 32'(cfg_ready), 32'd1);
    tick();
    cfg_valid = 1'b0; cfg_last = 1'b0;
  endtask

  task automatic send_frame(input logic [47:0] fr, input int nwords, input int last_at);
    logic [7:0] b;
    for (int k = 0; k < nwords; k++) begin
      b = (k < 6) ? fr[k*8 +: 8] : 8'h00;
      send_word(b, k == last_at);
    end
  endtask

  // Called right after the last word is accepted: expects the commit cycle now.
  task automatic expect_commit(input string name, input int d0);
    check({name, "_done"}, 32'(cfg_done), 32'd1);
    check({name, "_ready_low"}, 32'(cfg_ready), 32'd0);
    tick();
    tick();
    check({name, "_done_once"}, 32'(done_cnt - d0), 32'd1);
  endtask

  initial begin
    int d0, n_low, n_done, k, guard;

    vecs[0] = '{1'b1, 1'b0, 1'b0, 1'b0, 3'b000, 3'b000, 10'b0000_000_000};
    vecs[1] = '{1'b1, 1'b1, 1'b1, 1'b1, 3'b001, 3'b001, 10'b1010_001_100};
    vecs[2] = '{1'b1, 1'b1, 1'b0, 1'b1, 3'b000, 3'b001, 10'b0000_000_000};
    vecs[3] = '{1'b0, 1'b0, 1'b1, 1'b0, 3'b110, 3'b110, 10'b0010_100_110};
    vecs[4] = '{1'b1, 1'b1, 1'b0, 1'b1, 3'b011, 3'b111, 10'b1000_101_110};
    v_err   = '{1'b0, 1'b0, 1'b1, 1'b0, 3'b001, 3'b000, 10'b0010_001_000};
    v_ones  = '{1'b1, 1'b1, 1'b1, 1'b1, 3'b111, 3'b111, 10'b0};

    // Reset state
    rst_n = 1'b0; cfg_valid = 1'b0; cfg_last = 1'b0; cfg_data = '0;
    drive('{1'b1, 1'b1, 1'b1, 1'b1, 3'b101, 3'b101, 10'b0});
    #12;
    check("rst_outs", 32'(outs), 32'd0);
    check("rst_sc_h", 32'(sc_H_o), 32'd0);
    @(posedge clk); #1 rst_n = 1'b1;
    tick();
    check("rst_ready", 32'(cfg_ready), 32'd1);
    check("rst_done", 32'(cfg_done), 32'd0);
    check("rst_err", 32'(cfg_err), 32'd0);

    // Good frame F1, then the combinational vector table
    d0 = done_cnt;
    send_frame(f1, 6, 5);
    expect_commit("f1", d0);
    check("f1_err", 32'(cfg_err), 32'd0);
    for (int i = 0; i < 5; i++) apply_vec(vecs[i], $sformatf("vec%0d", i));

    // F2: registered LUT output lags one clock
    d0 = done_cnt;
    send_frame(f2, 6, 5);
    expect_commit("f2", d0);
    apply_vec('{1'b0, 1'b0, 1'b0, 1'b0, 3'b000, 3'b000, 10'b0}, "ff_zero");
    drive('{1'b1, 1'b1, 1'b0, 1'b0, 3'b001, 3'b001, 10'b0});
    #1 check("ff_pre_rise", 32'(lc_V_o), 32'd0);
    tick();
    check("ff_post_rise", 32'(lc_V_o), 32'd1);
    check("ff_trk_v", 32'(sc_V_o), 32'b100);
    drive('{1'b0, 1'b0, 1'b0, 1'b0, 3'b000, 3'b000, 10'b0});
    #1 check("ff_pre_fall", 32'(lc_V_o), 32'd1);
    tick();
    check("ff_post_fall", 32'(lc_V_o), 32'd0);

    // Short frame: last on word 3
    d0 = done_cnt;
    send_frame(fz, 4, 3);
    check("short_err", 32'(cfg_err), 32'd1);
    tick();
    check("short_no_done", 32'(done_cnt - d0), 32'd0);
    apply_vec(v_err, "short_keep_a");

    // Good frame clears the error on its first word
    d0 = done_cnt;
    send_word(f1[7:0], 1'b0);
    check("err_clear_w0", 32'(cfg_err), 32'd0);
    for (int i = 1; i < 6; i++) send_word(f1[i*8 +: 8], i == 5);
    expect_commit("f1_again", d0);
    apply_vec(vecs[1], "f1_again_vec");

    // Overlong frame: 8 words, last on word 7
    d0 = done_cnt;
    for (int i = 0; i < 6; i++) send_word(8'h00, 1'b0);
    check("long_err", 32'(cfg_err), 32'd1);
    check("long_drain_ready", 32'(cfg_ready), 32'd1);
    send_word(8'h00, 1'b0);
    send_word(8'h00, 1'b1);
    tick();
    check("long_no_done", 32'(done_cnt - d0), 32'd0);
    apply_vec(vecs[1], "long_keep_a");

    // Following good all-zero frame commits
    d0 = done_cnt;
    send_frame(fz, 6, 5);
    expect_commit("zero", d0);
    check("zero_err", 32'(cfg_err), 32'd0);
    apply_vec(v_ones, "zero_outs");

    // Valid held high across two back-to-back frames
    n_low = 0; n_done = 0; k = 0; guard = 0;
    cfg_valid = 1'b1;
    while (k < 12 && guard < 100) begin
      cfg_data = (k < 6) ? fz[k*8 +: 8] : f1[(k-6)*8 +: 8];
      cfg_last = (k == 5) || (k == 11);
      if (cfg_done === 1'b1) n_done++;
      if (cfg_ready !== 1'b1) n_low++;
      else k++;
      tick();
      guard++;
    end
    cfg_valid = 1'b0; cfg_last = 1'b0;
    check("stream_words", 32'(k), 32'd12);
    check("stream_ready_low", 32'(n_low), 32'd1);
    check("stream_mid_done", 32'(n_done), 32'd1);
    check("stream_final_done", 32'(cfg_done), 32'd1);
    tick();
    check("stream_err", 32'(cfg_err), 32'd0);
    apply_vec(vecs[1], "stream_vec");

    // Reset pulsed mid-frame
    send_frame(f2, 3, 99);
    drive(v_ones);
    #2 rst_n = 1'b0;
    #2;
    check("midrst_outs", 32'(outs), 32'd0);
    check("midrst_ready", 32'(cfg_ready), 32'd1);
    @(posedge clk); #1 rst_n = 1'b1;
    apply_vec(v_ones, "midrst_outs_after");
    check("midrst_err", 32'(cfg_err), 32'd0);
    d0 = done_cnt;
    send_frame(f1, 6, 5);
    expect_commit("post_rst", d0);
    apply_vec(vecs[1], "post_rst_vec");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "watchdog");
  end

endmodule
